// File: rtl/fpu_iterative_divider.sv
// Multi-cycle floating-point divider: radix-2 restoring mantissa division,
// round-to-nearest-even, flush-to-zero, valid/ready handshake on both sides.
module fpu_iterative_divider #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned WIDTH = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             underflow,
  output logic             div_by_zero,
  output logic             invalid
);

  localparam int unsigned Q     = MAN_W + 3;
  localparam int unsigned CNT_W = $clog2(Q);
  localparam int unsigned R_W   = MAN_W + 2;
  localparam int unsigned E_W   = EXP_W + 2;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(Q - 1);
  localparam logic signed [E_W-1:0] E_BIAS   = E_W'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [E_W-1:0] E_MAX    = E_W'(2 ** EXP_W - 1);
  localparam logic signed [E_W-1:0] E_ZERO   = '0;
  localparam logic signed [E_W-1:0] E_ONE    = E_W'(1);
  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;
  state_t state, state_next;

  logic [R_W-1:0]        rem;
  logic [MAN_W:0]        mb;
  logic [Q-1:0]          quo;
  logic [CNT_W-1:0]      cnt;
  logic signed [E_W-1:0] e;
  logic                  sign;

  // Operand unpacking and classification
  logic             sa, sb, sign_c;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [E_W-1:0] ea_s, eb_s, e_init;

  assign {sa, ea, fa} = A;
  assign {sb, eb, fb} = B;
  assign sign_c = sa ^ sb;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);
  assign ea_s   = {2'b00, ea};
  assign eb_s   = {2'b00, eb};
  assign e_init = ea_s - eb_s + E_BIAS;

  // Special-case result selection; Inf/0 is treated as Inf/finite (no flag)
  logic             special_c, spec_invalid, spec_dbz;
  logic [WIDTH-1:0] spec_result;

  always_comb begin
    special_c    = 1'b1;
    spec_invalid = 1'b0;
    spec_dbz     = 1'b0;
    spec_result  = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_result  = QNAN;
      spec_invalid = 1'b1;
    end else if (a_inf) begin
      spec_result = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_dbz = 1'b1;
    end else if (b_inf || a_zero) begin
      spec_result = {sign_c, {(WIDTH-1){1'b0}}};
    end else begin
      special_c = 1'b0;
    end
  end

  // One restoring-division step
  logic           ge;
  logic [R_W-1:0] rem_sel, rem_nxt;

  always_comb begin
    ge      = (rem >= {1'b0, mb});
    rem_sel = ge ? (rem - {1'b0, mb}) : rem;
    rem_nxt = rem_sel << 1;
  end

  // Normalise, round to nearest even, range-check
  logic                  guard, sticky, inc, ovf_c, unf_c;
  logic [MAN_W:0]        kept;
  logic [MAN_W+1:0]      sum;
  logic [MAN_W-1:0]      frac;
  logic signed [E_W-1:0] e_norm, e_fin;
  logic [WIDTH-1:0]      rnd_result;

  always_comb begin
    if (quo[Q-1]) begin
      kept   = quo[Q-1:2];
      guard  = quo[1];
      sticky = quo[0] | (|rem);
      e_norm = e;
    end else begin
      kept   = quo[Q-2:1];
      guard  = quo[0];
      sticky = |rem;
      e_norm = e - E_ONE;
    end
    inc = guard & (sticky | kept[0]);
    sum = {1'b0, kept} + {{(MAN_W+1){1'b0}}, inc};
    if (sum[MAN_W+1]) begin
      frac  = sum[MAN_W:1];
      e_fin = e_norm + E_ONE;
    end else begin
      frac  = sum[MAN_W-1:0];
      e_fin = e_norm;
    end
    ovf_c = (e_fin >= E_MAX);
    unf_c = (e_fin <= E_ZERO);
    if (ovf_c)      rnd_result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf_c) rnd_result = {sign, {(WIDTH-1){1'b0}}};
    else            rnd_result = {sign, e_fin[EXP_W-1:0], frac};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = special_c ? DONE : DIVIDE;
      DIVIDE:  if (cnt == CNT_LAST) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath, result and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem         <= '0;
      mb          <= '0;
      quo         <= '0;
      cnt         <= '0;
      e           <= '0;
      sign        <= 1'b0;
      result      <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign        <= sign_c;
          rem         <= {2'b01, fa};
          mb          <= {1'b1, fb};
          quo         <= '0;
          cnt         <= '0;
          e           <= e_init;
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          div_by_zero <= spec_dbz;
          invalid     <= spec_invalid;
          if (special_c) result <= spec_result;
        end
        DIVIDE: begin
          rem <= rem_nxt;
          quo <= {quo[Q-2:0], ge};
          cnt <= cnt + CNT_W'(1);
        end
        ROUND: begin
          result    <= rnd_result;
          overflow  <= ovf_c;
          underflow <= unf_c;
        end
        DONE: if (out_ready) begin
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          div_by_zero <= 1'b0;
          invalid     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
